// File: rtl/sd_cmd_sequencer_if.sv
// sd_cmd_sequencer_if: command request/response and byte-engine signals of the SD command sequencer
interface sd_cmd_sequencer_if;
  logic        cmd_valid_i;
  logic [5:0]  cmd_index_i;
  logic [31:0] cmd_arg_i;
  logic [6:0]  cmd_crc_i;
  logic        cmd_long_i;
  logic        cmd_ready_o;
  logic        busy_o;
  logic        cs_n_o;
  logic        eng_start_o;
  logic [7:0]  eng_tx_o;
  logic [7:0]  eng_rx_i;
  logic        eng_done_i;
  logic [7:0]  resp_r1_o;
  logic [31:0] resp_data_o;
  logic        done_o;
  logic        err_timeout_o;
  modport slave (
    input  cmd_valid_i, cmd_index_i, cmd_arg_i, cmd_crc_i, cmd_long_i, eng_rx_i, eng_done_i,
    output cmd_ready_o, busy_o, cs_n_o, eng_start_o, eng_tx_o, resp_r1_o, resp_data_o, done_o, err_timeout_o
  );
  modport master (
    output cmd_valid_i, cmd_index_i, cmd_arg_i, cmd_crc_i, cmd_long_i, eng_rx_i, eng_done_i,
    input  cmd_ready_o, busy_o, cs_n_o, eng_start_o, eng_tx_o, resp_r1_o, resp_data_o, done_o, err_timeout_o
  );
endinterface

// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer: runs one SPI-mode SD command (frame, R1 poll, optional 32-bit trailer) over a byte engine
module sd_cmd_sequencer #(
  parameter int NCR_MAX    = 8,
  parameter int DATA_WIDTH = 8
) (
  input logic               spi_clk_i,
  input logic               spi_rst_i,
  sd_cmd_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PRE, CMD, WAIT_R1, RESP, POST, DONE} state_t;
  state_t                r_state;
  logic                  r_start, r_cs_n, r_done, r_timeout, r_long;
  logic [DATA_WIDTH-1:0] r_tx;
  logic [7:0]            r_r1, r_poll;
  logic [31:0]           r_arg, r_data;
  logic [5:0]            r_index;
  logic [6:0]            r_crc;
  logic [2:0]            r_cnt;
  logic                  w_take;
  logic [2:0]            w_sel;
  logic [7:0]            w_frame, w_poll_n;
  // a done pulse landing in the issue cycle belongs to no exchange of ours
  assign w_take   = bus.eng_done_i && !r_start;
  assign w_sel    = (r_state == PRE) ? 3'd0 : r_cnt + 3'd1;
  assign w_poll_n = r_poll + 8'd1;
  always_comb
    w_frame = (w_sel == 3'd0) ? {2'b01, r_index} :
              (w_sel == 3'd1) ? r_arg[31:24] :
              (w_sel == 3'd2) ? r_arg[23:16] :
              (w_sel == 3'd3) ? r_arg[15:8] :
              (w_sel == 3'd4) ? r_arg[7:0] : {r_crc, 1'b1};
  always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
    if (spi_rst_i) begin
      r_state   <= IDLE;
      r_start   <= 1'b0;
      r_cs_n    <= 1'b1;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_long    <= 1'b0;
      r_tx      <= 8'hFF;
      r_r1      <= 8'hFF;
      r_data    <= 32'd0;
      r_poll    <= 8'd0;
      r_cnt     <= 3'd0;
      r_arg     <= 32'd0;
      r_index   <= 6'd0;
      r_crc     <= 7'd0;
    end else begin
      r_start <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: if (bus.cmd_valid_i) begin
          r_index   <= bus.cmd_index_i;
          r_arg     <= bus.cmd_arg_i;
          r_crc     <= bus.cmd_crc_i;
          r_long    <= bus.cmd_long_i;
          r_timeout <= 1'b0;
          r_cs_n    <= 1'b0;
          r_start   <= 1'b1;
          r_tx      <= 8'hFF;
          r_cnt     <= 3'd0;
          r_poll    <= 8'd0;
          r_state   <= PRE;
        end
        PRE: if (w_take) begin
          r_start <= 1'b1;
          r_cnt   <= 3'd0;
          r_tx    <= w_frame;
          r_state <= CMD;
        end
        CMD: if (w_take) begin
          r_start <= 1'b1;
          if (r_cnt == 3'd5) begin
            r_tx    <= 8'hFF;
            r_poll  <= 8'd0;
            r_state <= WAIT_R1;
          end else begin
            r_cnt <= r_cnt + 3'd1;
            r_tx  <= w_frame;
          end
        end
        WAIT_R1: if (w_take) begin
          r_start <= 1'b1;
          r_poll  <= w_poll_n;
          if (!bus.eng_rx_i[7]) begin
            r_r1    <= bus.eng_rx_i;
            r_cnt   <= 3'd0;
            r_state <= r_long ? RESP : POST;
          end else if (w_poll_n == NCR_MAX[7:0]) begin
            r_r1      <= 8'hFF;
            r_timeout <= 1'b1;
            r_state   <= POST;
          end
        end
        RESP: if (w_take) begin
          r_start <= 1'b1;
          r_data  <= {r_data[23:0], bus.eng_rx_i};
          r_cnt   <= r_cnt + 3'd1;
          if (r_cnt == 3'd3) r_state <= POST;
        end
        POST: if (w_take) begin
          r_cs_n  <= 1'b1;
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.cmd_ready_o   = (r_state == IDLE);
  assign bus.busy_o        = (r_state != IDLE);
  assign bus.cs_n_o        = r_cs_n;
  assign bus.eng_start_o   = r_start;
  assign bus.eng_tx_o      = r_tx;
  assign bus.resp_r1_o     = r_r1;
  assign bus.resp_data_o   = r_data;
  assign bus.done_o        = r_done;
  assign bus.err_timeout_o = r_timeout;
endmodule
